relu_requant: RTL and testbench
===============================

Name: relu_requant

Overview:
- Downstream neighbour of the accumulator stage. Consumes accumulated GROUP_SIZE-lane words.
- Per lane, in order: optional ReLU, arithmetic right shift (requantization), saturating clip to a narrower signed output width.
- Configured per run with an item count, like the accumulator. Uses the same valid/avail flow control.
- Output is registered, so this block also cuts the timing path to the next stage.

Parameters:
- DATA_WIDTH, 16: input lane width, signed two's complement.
- OUT_WIDTH, 8: output lane width, signed; must be ≤ DATA_WIDTH.
- GROUP_SIZE, 4: lanes per word.
- LOG_MAX_ITEMS, 16: width of the item counter.
- LOG_MAX_SHIFT, 4: width of the shift amount.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- configure  in  1  CONFIGURE: latch the configuration fields below
- num_items  in  LOG_MAX_ITEMS  CONFIGURE: words to process this run (0 is illegal)
- shift  in  LOG_MAX_SHIFT  CONFIGURE: arithmetic right-shift amount
- relu_enable  in  1  CONFIGURE: clamp negative lanes to 0
- clip_min  in  OUT_WIDTH  CONFIGURE: signed lower bound
- clip_max  in  OUT_WIDTH  CONFIGURE: signed upper bound; clip_min ≤ clip_max is required
- data_in  in  GROUP_SIZE*DATA_WIDTH  IN: data, lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- valid_in  in  1  IN: valid
- avail_out  out  1  IN: avail
- data_out  out  GROUP_SIZE*OUT_WIDTH  OUT: data
- valid_out  out  1  OUT: valid
- avail_in  in  1  OUT: avail

Behaviour:
- Reset (rst=0, async): all configuration registers 0, item counter 0, enable 0, data_out 0, valid_out 0, input FIFO emptied. avail_out=1 from the first cycle after reset release.
- Input buffering: 4-slot FIFO.
  - avail_out = ~almost_full & ~full.
  - Upstream writes only when valid_in=1. A write while full is dropped; the bench flags it as an error.
- Operation fire: fire = enabled & ~fifo_empty & avail_in & ~configure.
  - On fire: pop one FIFO word and register the result.
  - Next cycle: valid_out=1 and data_out=result. Latency is one cycle from FIFO head to output.
  - Without a fire, valid_out=0 next cycle and data_out holds its last value.
- Downstream contract: avail_in must already be deasserted whenever the downstream has fewer than 2 free slots (almost-full convention).
- Lane arithmetic, per lane x (signed, DATA_WIDTH):
  - r = (relu_enable & x<0) ? 0 : x
  - s = r >>> shift (sign-extending)
  - y = s<clip_min ? clip_min : s>clip_max ? clip_max : s[OUT_WIDTH-1:0]
  - All comparisons are signed at DATA_WIDTH, with clip bounds sign-extended.
- Control counter:
  - configure=1: latch all fields, items_r=num_items, enable=1.
  - configure has priority over fire; no fire occurs in a configure cycle.
  - On fire with items_r==1: enable<=0, items_r<=0.
  - On fire otherwise: items_r decrements.
- Boundaries:
  - Reconfigure mid-run restarts the count and discards the old remaining count. FIFO contents are kept and are processed under the new configuration.
  - shift ≥ DATA_WIDTH yields 0 for non-negative lanes and -1 for negative lanes.
  - Input accepted while not enabled waits in the FIFO. No output is produced until the next configure.
  - Reset asserted mid-run aborts the run immediately; the next cycle behaves as after reset.

Optional Feature:
- Macro: RELU_REQUANT_ROUND_EN.
- Defined: round half up before the shift. When shift>0, s = (r + (1<<(shift-1))) >>> shift, with the addition done at DATA_WIDTH+1 bits to avoid overflow, then clipped as above.
- Undefined: truncating shift only, with no rounding adder synthesized.

Decomposition:
- Shared package/header:
  - lane-slice macro or function;
  - default widths (DATA_WIDTH, OUT_WIDTH, GROUP_SIZE);
  - FIFO depth constant (4) and almost-full threshold, shared with the accumulator.
- Reuse the existing FIFO module for input buffering.
- One sub-module is natural: relu_requant_lane, the combinational ReLU/shift/(round)/clip for one lane, instantiated GROUP_SIZE times in a generate loop. Registers stay in the top module.

Test Plan:
- Passthrough: configure num_items=3, shift=0, relu=0, clip [-128,127]. Lanes {5,-7,100,-100} → data_out {5,-7,100,-100}, valid_out one cycle after FIFO pop, 3 outputs, then enable=0.
- ReLU+shift: relu=1, shift=2. Lanes {-40,40,13,1023}, clip [-128,127] → {0,10,3,127} (1023>>2=255 saturates to 127).
- Negative clip: relu=0, shift=4, clip [-100,100]. Lanes {-32768,-17,16,0} → {-100,-2,1,0}. With ROUND_EN: -17→-1, 16→1.
- Back-pressure: hold avail_in=0 for 10 cycles while pushing 4 words → avail_out drops after the FIFO reaches almost full, valid_out stays 0, no words are lost. Release → 4 outputs in 4 consecutive cycles, in order.
- Reconfigure mid-run: num_items=8; after 3 outputs configure num_items=2 → exactly 2 further outputs, then idle. No fire in the configure cycle.
- Async reset mid-run: assert rst=0 between clock edges with valid_out=1 → valid_out=0 and data_out=0 immediately, FIFO empty. After release, output stays idle until a new configure.

Source files
------------

// File: rtl/relu_requant_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_requant_pkg                                                     |
// | Shared widths, input-FIFO sizing and lane-slicing helper.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package relu_requant_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int DEF_GROUP_SIZE = 4;

    // Shared with the accumulator stage so both ends agree on the slack.
    localparam int FIFO_DEPTH     = 4;
    localparam int FIFO_AF_LEVEL  = FIFO_DEPTH - 1;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_requant_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_requant_if                                                      |
// | valid/avail stream bundle; avail flows from sink back to source.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface relu_requant_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             avail;

    modport master (output data, output valid, input  avail);
    modport slave  (input  data, input  valid, output avail);
endinterface
`default_nettype wire

// File: rtl/relu_requant_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_requant_lane                                                    |
// | One lane: ReLU, arithmetic right shift, signed clip (combinational). |
// | RELU_REQUANT_ROUND_EN adds round-half-up before the shift.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module relu_requant_lane
    import relu_requant_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int LOG_MAX_SHIFT = 4
) (
    input  wire logic signed [DATA_WIDTH-1:0]    i_x,
    input  wire logic        [LOG_MAX_SHIFT-1:0] i_shift,
    input  wire logic                            i_relu_enable,
    input  wire logic signed [OUT_WIDTH-1:0]     i_clip_min,
    input  wire logic signed [OUT_WIDTH-1:0]     i_clip_max,
    output logic             [OUT_WIDTH-1:0]     o_y
);
    // One guard bit keeps the rounding bias from overflowing.
    localparam int EW = DATA_WIDTH + 1;

    logic signed [EW-1:0] w_relu;
    logic signed [EW-1:0] w_biased;
    logic signed [EW-1:0] w_shifted;
    logic signed [EW-1:0] w_lo;
    logic signed [EW-1:0] w_hi;

    always_comb begin
        w_relu = (i_relu_enable && i_x[DATA_WIDTH-1]) ? '0 : {i_x[DATA_WIDTH-1], i_x};
        w_biased = w_relu;
`ifdef RELU_REQUANT_ROUND_EN
        if (i_shift != '0) begin
            w_biased = w_relu + $signed(EW'(1) << (i_shift - 1'b1));
        end
`endif
        w_shifted = w_biased >>> i_shift;
        w_lo = {{(EW - OUT_WIDTH){i_clip_min[OUT_WIDTH-1]}}, i_clip_min};
        w_hi = {{(EW - OUT_WIDTH){i_clip_max[OUT_WIDTH-1]}}, i_clip_max};
        if (w_shifted < w_lo) begin
            o_y = i_clip_min;
        end else if (w_shifted > w_hi) begin
            o_y = i_clip_max;
        end else begin
            o_y = w_shifted[OUT_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_fifo                                                          |
// | Small synchronous FIFO with full/almost-full flags, async low reset. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stream_fifo #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr_en,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_rd_en,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    // Writes into a full FIFO are dropped rather than overwriting the head.
    assign w_wr          = i_wr_en & ~o_full;
    assign w_rd          = i_rd_en & ~o_empty;
    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == CW'(DEPTH));
    assign o_almost_full = (r_count >= CW'(AF_LEVEL));
    assign o_rd_data     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/relu_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_requant                                                         |
// | Buffered per-lane ReLU/requantise/clip with registered output.       |
// | Optional macro RELU_REQUANT_ROUND_EN enables round-half-up.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module relu_requant
    import relu_requant_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int GROUP_SIZE    = DEF_GROUP_SIZE,
    parameter int LOG_MAX_ITEMS = 16,
    parameter int LOG_MAX_SHIFT = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     configure,
    input  wire logic [LOG_MAX_ITEMS-1:0] num_items,
    input  wire logic [LOG_MAX_SHIFT-1:0] shift,
    input  wire logic                     relu_enable,
    input  wire logic [OUT_WIDTH-1:0]     clip_min,
    input  wire logic [OUT_WIDTH-1:0]     clip_max,
    relu_requant_if.slave                 up,
    relu_requant_if.master                dn
);
    localparam int IN_W  = GROUP_SIZE * DATA_WIDTH;
    localparam int OUT_W = GROUP_SIZE * OUT_WIDTH;

    logic [LOG_MAX_ITEMS-1:0] r_items;
    logic                     r_enable;
    logic [LOG_MAX_SHIFT-1:0] r_shift;
    logic                     r_relu;
    logic [OUT_WIDTH-1:0]     r_clip_min;
    logic [OUT_WIDTH-1:0]     r_clip_max;
    logic [OUT_W-1:0]         r_data_out;
    logic                     r_valid_out;

    logic [IN_W-1:0]          w_head;
    logic [OUT_W-1:0]         w_result;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_afull;
    logic                     w_fire;

    // A configure cycle never fires so the new settings apply from the next word.
    assign w_fire    = r_enable & ~w_empty & dn.avail & ~configure;
    assign up.avail  = ~w_afull & ~w_full;
    assign dn.data   = r_data_out;
    assign dn.valid  = r_valid_out;

    stream_fifo #(
        .WIDTH    (IN_W),
        .DEPTH    (FIFO_DEPTH),
        .AF_LEVEL (FIFO_AF_LEVEL)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (up.valid),
        .i_wr_data     (up.data),
        .i_rd_en       (w_fire),
        .o_rd_data     (w_head),
        .o_empty       (w_empty),
        .o_full        (w_full),
        .o_almost_full (w_afull)
    );

    for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_lane
        localparam int c_in_lsb  = lane_lsb(g, DATA_WIDTH);
        localparam int c_out_lsb = lane_lsb(g, OUT_WIDTH);

        relu_requant_lane #(
            .DATA_WIDTH    (DATA_WIDTH),
            .OUT_WIDTH     (OUT_WIDTH),
            .LOG_MAX_SHIFT (LOG_MAX_SHIFT)
        ) u_lane (
            .i_x           (w_head[c_in_lsb +: DATA_WIDTH]),
            .i_shift       (r_shift),
            .i_relu_enable (r_relu),
            .i_clip_min    (r_clip_min),
            .i_clip_max    (r_clip_max),
            .o_y           (w_result[c_out_lsb +: OUT_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_items     <= '0;
            r_enable    <= 1'b0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_clip_min  <= '0;
            r_clip_max  <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_fire;
            if (configure) begin
                r_items    <= num_items;
                r_enable   <= 1'b1;
                r_shift    <= shift;
                r_relu     <= relu_enable;
                r_clip_min <= clip_min;
                r_clip_max <= clip_max;
            end else if (w_fire) begin
                r_data_out <= w_result;
                if (r_items == LOG_MAX_ITEMS'(1)) begin
                    r_enable <= 1'b0;
                    r_items  <= '0;
                end else begin
                    r_items  <= r_items - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_relu_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_relu_requant                                                      |
// | Directed bench with a queue-based reference model of relu_requant.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_relu_requant;
    localparam int DW = 16;
    localparam int OW = 8;
    localparam int G  = 4;
    localparam int LI = 16;
    localparam int LS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          configure = 1'b0;
    logic [LI-1:0] num_items = '0;
    logic [LS-1:0] shift = '0;
    logic          relu_enable = 1'b0;
    logic [OW-1:0] clip_min = '0;
    logic [OW-1:0] clip_max = '0;

    relu_requant_if #(.WIDTH(G*DW)) up_if ();
    relu_requant_if #(.WIDTH(G*OW)) dn_if ();

    relu_requant #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .GROUP_SIZE(G),
        .LOG_MAX_ITEMS(LI), .LOG_MAX_SHIFT(LS)
    ) dut (
        .clk(clk), .rst(rst), .configure(configure), .num_items(num_items),
        .shift(shift), .relu_enable(relu_enable), .clip_min(clip_min),
        .clip_max(clip_max), .up(up_if), .dn(dn_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [G*DW-1:0] m_q[$];
    bit              m_en = 0;
    int              m_items = 0;
    int              m_shift = 0;
    bit              m_relu = 0;
    int              m_lo = 0;
    int              m_hi = 0;
    bit              exp_valid = 0;
    logic [G*OW-1:0] exp_data = '0;
    logic [G*OW-1:0] obs[$];

    function automatic int ref_lane(int x, int sh, bit relu, int lo, int hi);
        longint r;
        longint s;
        r = (relu && x < 0) ? 64'sd0 : longint'(x);
`ifdef RELU_REQUANT_ROUND_EN
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
        s = r >>> sh;
        if (s < lo) return lo;
        if (s > hi) return hi;
        return int'(s);
    endfunction

    function automatic logic [G*OW-1:0] ref_word(logic [G*DW-1:0] w, int sh, bit relu, int lo, int hi);
        logic [G*OW-1:0] res;
        logic [DW-1:0]   x;
        logic [31:0]     y;
        res = '0;
        for (int i = 0; i < G; i++) begin
            x = w[i*DW +: DW];
            y = ref_lane(int'($signed(x)), sh, relu, lo, hi);
            res[i*OW +: OW] = y[OW-1:0];
        end
        return res;
    endfunction

    function automatic logic [G*DW-1:0] pack_in(int a, int b, int c, int d);
        int v[4];
        logic [31:0] t;
        logic [G*DW-1:0] r;
        v = '{a, b, c, d};
        r = '0;
        for (int i = 0; i < G; i++) begin
            t = v[i];
            r[i*DW +: DW] = t[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [G*OW-1:0] pack_out(int a, int b, int c, int d);
        int v[4];
        logic [31:0] t;
        logic [G*OW-1:0] r;
        v = '{a, b, c, d};
        r = '0;
        for (int i = 0; i < G; i++) begin
            t = v[i];
            r[i*OW +: OW] = t[OW-1:0];
        end
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_en = 0; m_items = 0; m_shift = 0; m_relu = 0; m_lo = 0; m_hi = 0;
        exp_valid = 0; exp_data = '0;
    endtask

    task automatic model_step();
        int sz0;
        bit fire;
        logic [G*DW-1:0] w;
        sz0  = m_q.size();
        fire = m_en && sz0 > 0 && dn_if.avail && !configure;
        if (configure) begin
            m_items = int'(num_items);
            m_en    = 1;
            m_shift = int'(shift);
            m_relu  = relu_enable;
            m_lo    = int'($signed(clip_min));
            m_hi    = int'($signed(clip_max));
        end else if (fire) begin
            w = m_q.pop_front();
            exp_data = ref_word(w, m_shift, m_relu, m_lo, m_hi);
            if (m_items == 1) begin
                m_en = 0; m_items = 0;
            end else begin
                m_items--;
            end
        end
        exp_valid = fire;
        if (up_if.valid) begin
            if (sz0 == 4) begin
                n_bad++;
                $display("FAIL overflow_write: write while full, size %0d limit 4", sz0);
            end else begin
                m_q.push_back(up_if.data);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) model_step();
    end

    initial forever begin
        @(negedge rst);
        model_clear();
    end

    initial forever begin
        @(negedge clk);
        check("valid_out", 64'(dn_if.valid), 64'(exp_valid));
        check("data_out", 64'(dn_if.data), 64'(exp_data));
        check("avail_out", 64'(up_if.avail), 64'(m_q.size() < 3));
        if (dn_if.valid === 1'b1) obs.push_back(dn_if.data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(int n, int sh, bit relu, int lo, int hi);
        configure   = 1'b1;
        num_items   = LI'(n);
        shift       = LS'(sh);
        relu_enable = relu;
        clip_min    = OW'(lo);
        clip_max    = OW'(hi);
        tick();
        configure   = 1'b0;
    endtask

    task automatic push(logic [G*DW-1:0] w);
        up_if.valid = 1'b1;
        up_if.data  = w;
        tick();
        up_if.valid = 1'b0;
    endtask

    task automatic expect_out(string name, logic [G*OW-1:0] want);
        logic [G*OW-1:0] got;
        n_cmp++;
        if (obs.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got no output, expected %h", name, want);
        end else begin
            got = obs.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", name, got, want);
            end
        end
    endtask

    task automatic expect_idle(string name);
        n_cmp++;
        if (obs.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d extra outputs, expected 0", name, obs.size());
        end
        obs.delete();
    endtask

    logic [G*DW-1:0] w_a, w_b, w_c, w_g;
    logic [G*OW-1:0] o_c;

    initial begin
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.avail = 1'b1;
        #1 rst = 1'b0;

        // Pin the reference model with hand-computed lane results
        check("pin_sat", 64'(ref_lane(1023, 2, 1, -128, 127)), 64'(127));
        check("pin_relu", 64'(ref_lane(-40, 2, 1, -128, 127)), 64'(0));
        check("pin_shift", 64'(ref_lane(13, 2, 1, -128, 127)), 64'(3));
        check("pin_negclip", 64'(ref_lane(-32768, 4, 0, -100, 100)), 64'(-100));
`ifdef RELU_REQUANT_ROUND_EN
        check("pin_m17", 64'(ref_lane(-17, 4, 0, -100, 100)), 64'(-1));
`else
        check("pin_m17", 64'(ref_lane(-17, 4, 0, -100, 100)), 64'(-2));
        check("pin_bigshift_neg", 64'(ref_lane(-5, 20, 0, -128, 127)), 64'(-1));
        check("pin_bigshift_pos", 64'(ref_lane(5, 20, 0, -128, 127)), 64'(0));
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("reset_avail", 64'(up_if.avail), 64'(1));
        check("reset_valid", 64'(dn_if.valid), 64'(0));
        check("reset_data", 64'(dn_if.data), 64'(0));

        // Passthrough
        w_a = pack_in(5, -7, 100, -100);
        cfg(3, 0, 0, -128, 127);
        repeat (3) push(w_a);
        repeat (4) tick();
        for (int i = 0; i < 3; i++) expect_out("pass", pack_out(5, -7, 100, -100));
        expect_idle("pass_idle");

        // Words accepted while disabled wait, then ReLU + shift
        w_b = pack_in(-40, 40, 13, 1023);
        push(w_b);
        push(w_b);
        repeat (3) tick();
        expect_idle("disabled_wait");
        cfg(2, 2, 1, -128, 127);
        repeat (4) tick();
        expect_out("relu_shift0", pack_out(0, 10, 3, 127));
        expect_out("relu_shift1", pack_out(0, 10, 3, 127));
        expect_idle("relu_idle");

        // Negative clip window
        w_c = pack_in(-32768, -17, 16, 0);
`ifdef RELU_REQUANT_ROUND_EN
        o_c = pack_out(-100, -1, 1, 0);
`else
        o_c = pack_out(-100, -2, 1, 0);
`endif
        cfg(1, 4, 0, -100, 100);
        push(w_c);
        repeat (3) tick();
        expect_out("negclip", o_c);
        expect_idle("negclip_idle");

        // Back-pressure
        dn_if.avail = 1'b0;
        cfg(4, 0, 0, -128, 127);
        for (int i = 1; i <= 4; i++) push(pack_in(i, -i, 10*i, -10*i));
        repeat (10) tick();
        check("bp_avail_low", 64'(up_if.avail), 64'(0));
        expect_idle("bp_no_output");
        dn_if.avail = 1'b1;
        repeat (6) tick();
        for (int i = 1; i <= 4; i++) expect_out("bp_order", pack_out(i, -i, 10*i, -10*i));
        expect_idle("bp_idle");

        // Reconfigure mid-run
        dn_if.avail = 1'b0;
        cfg(8, 0, 0, -128, 127);
        for (int i = 0; i < 4; i++) push(pack_in(20+i, -20-i, i, -i));
        dn_if.avail = 1'b1;
        repeat (3) tick();
        cfg(2, 0, 0, -128, 127);
        push(pack_in(24, -24, 4, -4));
        push(pack_in(25, -25, 5, -5));
        repeat (4) tick();
        for (int i = 0; i < 5; i++) expect_out("reconf", pack_out(20+i, -20-i, i, -i));
        expect_idle("reconf_idle");

        // Async reset mid-run with valid_out high
        cfg(3, 0, 0, -128, 127);
        push(pack_in(30, 31, 32, 33));
        check("pre_reset_valid", 64'(dn_if.valid), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("rst_valid", 64'(dn_if.valid), 64'(0));
        check("rst_data", 64'(dn_if.data), 64'(0));
        check("rst_avail", 64'(up_if.avail), 64'(1));
        obs.delete();
        tick();
        tick();
        rst = 1'b1;
        w_g = pack_in(1, 2, 3, 4);
        push(w_g);
        repeat (4) tick();
        expect_idle("post_reset_idle");
        cfg(1, 0, 0, -128, 127);
        repeat (3) tick();
        expect_out("post_reset_run", pack_out(1, 2, 3, 4));
        expect_idle("post_reset_done");

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
